// File: rtl/sa_dma_sched.sv
// sa_dma_sched: run scheduler driving the K/X/Y DMA descriptor channels.
// Define SA_SCHED_PERF_EN to build the busy-cycle counter (CYCLES, index 13).
module sa_dma_sched #(
   parameter int ADDR_WIDTH = 32,
   parameter int LEN_WIDTH  = 32,
   parameter int ITER_WIDTH = 16,
   parameter int REG_WIDTH  = 32
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    reg_wr_valid,
   input  logic [3:0]              reg_wr_idx,
   input  logic [REG_WIDTH-1:0]    reg_wr_data,
   input  logic [3:0]              reg_rd_idx,
   output logic [REG_WIDTH-1:0]    reg_rd_data,
   output logic [2:0]              desc_valid,
   input  logic [2:0]              desc_ready,
   output logic [3*ADDR_WIDTH-1:0] desc_addr,
   output logic [3*LEN_WIDTH-1:0]  desc_len,
   input  logic [2:0]              dma_done,
   output logic                    irq
);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT, S_NEXT, S_DRAIN
   } state_t;

   state_t r_state, w_next;

   logic [ADDR_WIDTH-1:0] r_base     [3];
   logic [LEN_WIDTH-1:0]  r_len      [3];
   logic [ADDR_WIDTH-1:0] r_stride   [3];
   logic [ADDR_WIDTH-1:0] r_cur_addr [3];
   logic [LEN_WIDTH-1:0]  r_cur_len  [3];
   logic [ITER_WIDTH-1:0] r_iters;
   logic [ITER_WIDTH-1:0] r_iter_cnt;
   logic                  r_start;
   logic                  r_abort;
   logic                  r_st_done;
   logic                  r_st_abt;
   logic                  r_st_err;
   logic [2:0]            r_acc;
   logic [2:0]            r_dn;
   logic [2:0]            r_drv;
   logic                  r_irq;
   logic [REG_WIDTH-1:0]  r_rd;

   logic [2:0]            w_skip;
   logic [2:0]            w_hs;
   logic [2:0]            w_w1c;
   logic [ITER_WIDTH-1:0] w_cnt_nx;
   logic                  w_last;
   logic                  w_busy;
   logic                  w_drain_ok;
   logic                  w_go;
   logic                  w_err;
   logic                  w_fin;
   logic                  w_abt;
   logic                  w_wr_ctrl;
   logic [REG_WIDTH-1:0]  w_rd;
   logic [31:0]           w_cycles;

   assign w_skip = {r_cur_len[2] == '0, r_cur_len[1] == '0, r_cur_len[0] == '0};
   assign w_hs       = desc_valid & desc_ready;
   assign w_cnt_nx   = r_iter_cnt + ITER_WIDTH'(1);
   assign w_last     = (w_cnt_nx == r_iters);
   assign w_busy     = (r_state != S_IDLE);
   assign w_wr_ctrl  = reg_wr_valid && (reg_wr_idx == 4'd0);
   assign w_w1c      = (reg_wr_valid && reg_wr_idx == 4'd1) ? reg_wr_data[3:1] : 3'b000;
   // abort drains: every raised valid must be accepted, every accept must finish
   assign w_drain_ok = ((r_drv & ~r_acc) == 3'b000) && ((r_acc & ~r_dn) == 3'b000);

   assign desc_addr = {r_cur_addr[2], r_cur_addr[1], r_cur_addr[0]};
   assign desc_len  = {r_cur_len[2], r_cur_len[1], r_cur_len[0]};
   assign irq         = r_irq;
   assign reg_rd_data = r_rd;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (r_start && r_iters != '0) w_next = S_ISSUE;
         end
         S_ISSUE: begin
            if (r_abort) w_next = S_DRAIN;
            else if (&(r_acc | w_skip)) w_next = S_WAIT;
         end
         S_WAIT: begin
            if (r_abort) w_next = S_DRAIN;
            else if (&(r_dn | w_skip)) w_next = S_NEXT;
         end
         S_NEXT: begin
            if (r_abort) w_next = S_DRAIN;
            else if (w_last) w_next = S_IDLE;
            else w_next = S_ISSUE;
         end
         S_DRAIN: begin
            if (w_drain_ok) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      desc_valid = 3'b000;
      w_go       = 1'b0;
      w_err      = 1'b0;
      w_fin      = 1'b0;
      w_abt      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_go  = r_start && (r_iters != '0);
            w_err = r_start && (r_iters == '0);
         end
         S_ISSUE: desc_valid = ~w_skip & ~r_acc;
         S_NEXT:  w_fin = w_last && !r_abort;
         S_DRAIN: begin
            desc_valid = r_drv & ~r_acc;
            w_abt      = w_drain_ok;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int c = 0; c < 3; c++) begin
            r_base[c]   <= '0;
            r_len[c]    <= '0;
            r_stride[c] <= '0;
         end
         r_iters <= '0;
         r_start <= 1'b0;
         r_abort <= 1'b0;
      end else begin
         r_start <= w_wr_ctrl & reg_wr_data[0];
         r_abort <= w_wr_ctrl & reg_wr_data[1];
         if (reg_wr_valid) begin
            case (reg_wr_idx)
               4'd2:  r_base[0]   <= ADDR_WIDTH'(reg_wr_data);
               4'd3:  r_len[0]    <= LEN_WIDTH'(reg_wr_data);
               4'd4:  r_base[1]   <= ADDR_WIDTH'(reg_wr_data);
               4'd5:  r_len[1]    <= LEN_WIDTH'(reg_wr_data);
               4'd6:  r_base[2]   <= ADDR_WIDTH'(reg_wr_data);
               4'd7:  r_len[2]    <= LEN_WIDTH'(reg_wr_data);
               4'd8:  r_iters     <= ITER_WIDTH'(reg_wr_data);
               4'd9:  r_stride[0] <= ADDR_WIDTH'(reg_wr_data);
               4'd10: r_stride[1] <= ADDR_WIDTH'(reg_wr_data);
               4'd11: r_stride[2] <= ADDR_WIDTH'(reg_wr_data);
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int c = 0; c < 3; c++) begin
            r_cur_addr[c] <= '0;
            r_cur_len[c]  <= '0;
         end
         r_iter_cnt <= '0;
         r_acc      <= '0;
         r_dn       <= '0;
         r_drv      <= '0;
         r_irq      <= 1'b0;
         r_st_done  <= 1'b0;
         r_st_abt   <= 1'b0;
         r_st_err   <= 1'b0;
      end else begin
         r_irq     <= w_fin;
         r_st_done <= (r_st_done & ~w_w1c[0] & ~w_go) | w_fin;
         r_st_abt  <= (r_st_abt & ~w_w1c[1] & ~w_go) | w_abt;
         r_st_err  <= (r_st_err & ~w_w1c[2]) | w_err;
         if (r_state != S_DRAIN) r_drv <= desc_valid;
         if (w_go || r_state == S_NEXT) begin
            r_acc <= '0;
            r_dn  <= '0;
         end else begin
            r_acc <= r_acc | w_hs;
            r_dn  <= r_dn | (dma_done & (r_acc | w_hs));
         end
         if (w_go) begin
            r_iter_cnt <= '0;
            for (int c = 0; c < 3; c++) begin
               r_cur_addr[c] <= r_base[c];
               r_cur_len[c]  <= r_len[c];
            end
         end else if (r_state == S_NEXT) begin
            r_iter_cnt <= w_cnt_nx;
            for (int c = 0; c < 3; c++) begin
               r_cur_addr[c] <= r_cur_addr[c] + r_stride[c];
               r_cur_len[c]  <= r_len[c];
            end
         end
      end
   end

`ifdef SA_SCHED_PERF_EN
   logic [31:0] r_cycles;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cycles <= '0;
      end else if (w_go) begin
         r_cycles <= '0;
      end else if (w_busy && r_cycles != '1) begin
         r_cycles <= r_cycles + 32'd1;
      end
   end

   assign w_cycles = r_cycles;
`else
   assign w_cycles = '0;
`endif

   always_comb begin
      w_rd = '0;
      case (reg_rd_idx)
         4'd1:  w_rd = REG_WIDTH'({r_st_err, r_st_abt, r_st_done, w_busy});
         4'd2:  w_rd = REG_WIDTH'(r_base[0]);
         4'd3:  w_rd = REG_WIDTH'(r_len[0]);
         4'd4:  w_rd = REG_WIDTH'(r_base[1]);
         4'd5:  w_rd = REG_WIDTH'(r_len[1]);
         4'd6:  w_rd = REG_WIDTH'(r_base[2]);
         4'd7:  w_rd = REG_WIDTH'(r_len[2]);
         4'd8:  w_rd = REG_WIDTH'(r_iters);
         4'd9:  w_rd = REG_WIDTH'(r_stride[0]);
         4'd10: w_rd = REG_WIDTH'(r_stride[1]);
         4'd11: w_rd = REG_WIDTH'(r_stride[2]);
         4'd12: w_rd = REG_WIDTH'(r_iter_cnt);
         4'd13: w_rd = REG_WIDTH'(w_cycles);
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rd <= '0;
      end else begin
         r_rd <= w_rd;
      end
   end

endmodule
